// File: rtl/mv_row_scheduler_if.sv
// Result stream of the row scheduler: show-ahead FIFO head with valid/ready.
// The scheduler drives it through the master modport and the consumer uses
// the slave modport.
interface mv_row_scheduler_if #(
    parameter int DW    = 32,
    parameter int ROW_W = 10
);
    logic             res_valid;
    logic [DW-1:0]    res_data;
    logic [ROW_W-1:0] res_index;
    logic             res_ready;

    modport master (output res_valid, res_data, res_index, input res_ready);
    modport slave  (input res_valid, res_data, res_index, output res_ready);
endinterface

// File: rtl/mv_row_scheduler.sv
// mv_row_scheduler: streams M matrix rows from the row buffer into the
// 16-lane dot-product pipeline against a held operand vector and queues the
// M scalar results, in issue order, in a show-ahead FIFO. A row is issued
// only when a FIFO slot is guaranteed for its result, because the pipeline
// cannot stall.
module mv_row_scheduler #(
    parameter int NUM        = 16,
    parameter int DW         = 32,
    parameter int ROW_W      = 10,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              vec_load,
    input  logic [DW*NUM-1:0] vec_data,
    output logic              busy,
    output logic              done,
    output logic              row_rd_en,
    output logic [ROW_W-1:0]  row_rd_addr,
    input  logic [DW*NUM-1:0] row_rd_data,
    output logic              dp_in_valid,
    output logic [DW*NUM-1:0] dp_a,
    output logic [DW*NUM-1:0] dp_b,
    input  logic              dp_res_valid,
    input  logic [DW-1:0]     dp_res_data,
    mv_row_scheduler_if.master res,
    output logic              err_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    // Wide enough for fifo_count + inflight, which never exceeds FIFO_DEPTH.
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ROW_W:0]    rows_q, rows_d;
    logic [ROW_W:0]    issued_q, issued_d;
    logic [ROW_W:0]    received_q, received_d;
    // Only ever presented as res_index, so the job-length bit is not kept.
    logic [ROW_W-1:0]  popped_q, popped_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DW*NUM-1:0] vec_q, vec_d;
    logic              dp_in_valid_q, dp_in_valid_d;
    logic              err_overflow_q, err_overflow_d;
    logic [DW-1:0]     fifo_mem [FIFO_DEPTH];

    logic [AW:0]       fifo_count;
    logic [CW-1:0]     reserved;
    logic              fifo_empty, fifo_full;
    logic              issue, accept, push, pop;

    // FIFO status, credit check and the per-cycle issue/accept/push/pop events.
    always_comb begin
        fifo_count = wr_ptr_q - rd_ptr_q;
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == FULL_CNT);
        reserved   = CW'(fifo_count) + inflight_q;
        issue      = (state_q == ISSUE) && (issued_q < rows_q) && (reserved < DEPTH);
        accept     = dp_res_valid && (state_q != IDLE);
        pop        = !fifo_empty && res.res_ready;
        // A result arriving at a full FIFO still lands if the head leaves this cycle.
        push       = accept && (!fifo_full || pop);
    end

    // Next-state logic for the sequencer, counters, FIFO pointers and operand register.
    always_comb begin
        state_d        = state_q;
        rows_d         = rows_q;
        issued_d       = issued_q;
        received_d     = received_q;
        popped_d       = popped_q;
        inflight_d     = inflight_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        vec_d          = vec_q;
        err_overflow_d = err_overflow_q;
        dp_in_valid_d  = issue;

        if (issue)  issued_d   = issued_q + 1'b1;
        if (accept) received_d = received_q + 1'b1;
        if (push)   wr_ptr_d   = wr_ptr_q + 1'b1;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            popped_d = popped_q + 1'b1;
        end
        if (accept && !push) err_overflow_d = 1'b1;

        case ({issue, accept})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        unique case (state_q)
            IDLE: begin
                // Loading before starting means a same-cycle start uses the new vector.
                if (vec_load) vec_d = vec_data;
                if (start) begin
                    rows_d     = {1'b0, num_rows};
                    issued_d   = '0;
                    received_d = '0;
                    popped_d   = '0;
                    state_d    = (num_rows == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued_d == rows_q) state_d = DRAIN;
            end
            DRAIN: begin
                // Looking at next-cycle values puts done right after the final pop.
                if ((received_d == rows_q) && (wr_ptr_d == rd_ptr_d)) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and control registers; asynchronous reset returns everything to zero/IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rows_q         <= '0;
            issued_q       <= '0;
            received_q     <= '0;
            popped_q       <= '0;
            inflight_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            vec_q          <= '0;
            dp_in_valid_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rows_q         <= rows_d;
            issued_q       <= issued_d;
            received_q     <= received_d;
            popped_q       <= popped_d;
            inflight_q     <= inflight_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            vec_q          <= vec_d;
            dp_in_valid_q  <= dp_in_valid_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Result storage; contents are only visible through the valid-gated head.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= dp_res_data;
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign row_rd_en     = issue;
    assign row_rd_addr   = issue ? issued_q[ROW_W-1:0] : '0;
    assign dp_in_valid   = dp_in_valid_q;
    assign dp_a          = row_rd_data;
    assign dp_b          = vec_q;
    assign res.res_valid = !fifo_empty;
    assign res.res_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[AW-1:0]];
    assign res.res_index = popped_q;
    assign err_overflow  = err_overflow_q;
endmodule

// File: tb/tb_mv_row_scheduler.sv
// Directed bench for mv_row_scheduler: two instances (32- and 4-entry result
// FIFO) share all control inputs, each with its own row buffer and a
// latency-20 dot-product model working on integer-valued single floats.
module tb_mv_row_scheduler;
    localparam int NUM   = 16;
    localparam int DW    = 32;
    localparam int ROW_W = 10;
    localparam int LAT   = 20;
    localparam logic [31:0] F1 = 32'h3F800000;  // 1.0
    localparam logic [31:0] F2 = 32'h40000000;  // 2.0
    localparam logic [31:0] F3 = 32'h40400000;  // 3.0
    localparam logic [DW*NUM-1:0] V1 = {NUM{F1}};
    localparam logic [DW*NUM-1:0] V2 = {NUM{F2}};
    localparam logic [DW*NUM-1:0] V3 = {NUM{F3}};

    // 16*k for k = 1..10 as IEEE single
    logic [31:0] exp_x1 [10] = '{32'h41800000, 32'h42000000, 32'h42400000, 32'h42800000,
                                 32'h42A00000, 32'h42C00000, 32'h42E00000, 32'h43000000,
                                 32'h43100000, 32'h43200000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic vec_load = 1'b0;
    logic res_ready = 1'b0;
    logic [ROW_W-1:0]  num_rows = '0;
    logic [DW*NUM-1:0] vec_data = '0;

    logic              busy0, done0, row_rd_en0, dp_in_valid0, err0, dp_res_valid0;
    logic [ROW_W-1:0]  row_rd_addr0;
    logic [DW*NUM-1:0] row_rd_data0 = '0;
    logic [DW*NUM-1:0] dp_a0, dp_b0;
    logic [DW-1:0]     dp_res_data0;
    logic              busy4, done4, row_rd_en4, dp_in_valid4, err4, dp_res_valid4;
    logic [ROW_W-1:0]  row_rd_addr4;
    logic [DW*NUM-1:0] row_rd_data4 = '0;
    logic [DW*NUM-1:0] dp_a4, dp_b4;
    logic [DW-1:0]     dp_res_data4;

    mv_row_scheduler_if #(.DW(DW), .ROW_W(ROW_W)) rif0 ();
    mv_row_scheduler_if #(.DW(DW), .ROW_W(ROW_W)) rif4 ();
    assign rif0.res_ready = res_ready;
    assign rif4.res_ready = res_ready;

    mv_row_scheduler #(.NUM(NUM), .DW(DW), .ROW_W(ROW_W), .FIFO_DEPTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .vec_load(vec_load), .vec_data(vec_data), .busy(busy0), .done(done0),
        .row_rd_en(row_rd_en0), .row_rd_addr(row_rd_addr0), .row_rd_data(row_rd_data0),
        .dp_in_valid(dp_in_valid0), .dp_a(dp_a0), .dp_b(dp_b0),
        .dp_res_valid(dp_res_valid0), .dp_res_data(dp_res_data0),
        .res(rif0), .err_overflow(err0)
    );

    mv_row_scheduler #(.NUM(NUM), .DW(DW), .ROW_W(ROW_W), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
        .vec_load(vec_load), .vec_data(vec_data), .busy(busy4), .done(done4),
        .row_rd_en(row_rd_en4), .row_rd_addr(row_rd_addr4), .row_rd_data(row_rd_data4),
        .dp_in_valid(dp_in_valid4), .dp_a(dp_a4), .dp_b(dp_b4),
        .dp_res_valid(dp_res_valid4), .dp_res_data(dp_res_data4),
        .res(rif4), .err_overflow(err4)
    );

    always #5 clk = ~clk;

    // integer value of a non-negative integer-valued single (exponent 127..150)
    function automatic int f2i(input logic [31:0] f);
        int e;
        e = int'(f[30:23]);
        if (e < 127 || e > 150) return 0;
        return int'({1'b1, f[22:0]}) >> (150 - e);
    endfunction

    // single-precision encoding of 0 <= n < 2^24
    function automatic logic [31:0] i2f(input int n);
        int p;
        p = 0;
        if (n == 0) return 32'h0;
        for (int k = 0; k < 24; k++) if (n[k]) p = k;
        return {1'b0, 8'(127 + p), 23'(n << (23 - p))};
    endfunction

    function automatic logic [31:0] dot(input logic [DW*NUM-1:0] a, input logic [DW*NUM-1:0] b);
        int s;
        s = 0;
        for (int k = 0; k < NUM; k++) s += f2i(a[k*DW +: DW]) * f2i(b[k*DW +: DW]);
        return i2f(s);
    endfunction

    // row buffers: row r holds (r+1).0 in every lane, one cycle read latency
    always @(posedge clk) begin
        if (row_rd_en0) row_rd_data0 <= {NUM{i2f(int'(row_rd_addr0) + 1)}};
        if (row_rd_en4) row_rd_data4 <= {NUM{i2f(int'(row_rd_addr4) + 1)}};
    end

    // fixed-latency dot-product pipelines (not reset, so stale results keep flowing)
    logic [LAT-1:0] pv0 = '0;
    logic [LAT-1:0] pv4 = '0;
    logic [DW-1:0]  pd0 [LAT];
    logic [DW-1:0]  pd4 [LAT];
    assign dp_res_valid0 = pv0[LAT-1];
    assign dp_res_data0  = pd0[LAT-1];
    assign dp_res_valid4 = pv4[LAT-1];
    assign dp_res_data4  = pd4[LAT-1];
    always @(posedge clk) begin
        pv0 <= {pv0[LAT-2:0], dp_in_valid0};
        pv4 <= {pv4[LAT-2:0], dp_in_valid4};
        pd0[0] <= dp_in_valid0 ? dot(dp_a0, dp_b0) : '0;
        pd4[0] <= dp_in_valid4 ? dot(dp_a4, dp_b4) : '0;
        for (int i = 1; i < LAT; i++) begin
            pd0[i] <= pd0[i-1];
            pd4[i] <= pd4[i-1];
        end
    end

    // event counters and popped-result logs
    int cnt_rden0 = 0, cnt_rden4 = 0, cnt_done0 = 0, cnt_done4 = 0, cnt_rv0 = 0, cnt_dpv0 = 0;
    logic [31:0]      q_d0 [$];
    logic [31:0]      q_d4 [$];
    logic [ROW_W-1:0] q_i0 [$];
    logic [ROW_W-1:0] q_i4 [$];
    always @(negedge clk) begin
        if (row_rd_en0) cnt_rden0 <= cnt_rden0 + 1;
        if (row_rd_en4) cnt_rden4 <= cnt_rden4 + 1;
        if (done0) cnt_done0 <= cnt_done0 + 1;
        if (done4) cnt_done4 <= cnt_done4 + 1;
        if (rif0.res_valid) cnt_rv0 <= cnt_rv0 + 1;
        if (dp_res_valid0) cnt_dpv0 <= cnt_dpv0 + 1;
        if (rif0.res_valid && res_ready) begin
            q_d0.push_back(rif0.res_data);
            q_i0.push_back(rif0.res_index);
        end
        if (rif4.res_valid && res_ready) begin
            q_d4.push_back(rif4.res_data);
            q_i4.push_back(rif4.res_index);
        end
    end

    int checks = 0;
    int errors = 0;
    int b_rd0, b_rd4, b_dn0, b_dn4, b_rv0, b_dpv0, b_q0, b_q4;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snapshot();
        b_rd0 = cnt_rden0; b_rd4 = cnt_rden4; b_dn0 = cnt_done0; b_dn4 = cnt_done4;
        b_rv0 = cnt_rv0; b_dpv0 = cnt_dpv0; b_q0 = q_d0.size(); b_q4 = q_d4.size();
    endtask

    // drive one start (optionally with a vector load) and return one cycle after the sampling edge
    task automatic launch(input int m, input bit load, input logic [DW*NUM-1:0] v);
        snapshot();
        start = 1'b1;
        num_rows = ROW_W'(m);
        vec_load = load;
        vec_data = v;
        tick();
        start = 1'b0;
        vec_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy0 || busy4) && n < budget) begin
            tick();
            n++;
        end
        check(tag, {busy0, busy4}, 2'b00);
    endtask

    // results since base: k-th result must be 16*mult*(k+1) with index k
    task automatic check_res(input string tag, input bit inst4, input int base, input int n, input int mult);
        int sz;
        sz = inst4 ? q_d4.size() : q_d0.size();
        check({tag, "_count"}, sz - base, n);
        for (int k = 0; k < n && base + k < sz; k++) begin
            check($sformatf("%s_data%0d", tag, k), inst4 ? q_d4[base+k] : q_d0[base+k], exp_x1[(k+1)*mult-1]);
            check($sformatf("%s_idx%0d", tag, k), inst4 ? q_i4[base+k] : q_i0[base+k], k);
        end
    endtask

    initial begin
        int run, bad;

        // reset state
        repeat (3) tick();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_rd_en", row_rd_en0, 0);
        check("rst_rd_addr", row_rd_addr0, 0);
        check("rst_dp_in_valid", dp_in_valid0, 0);
        check("rst_dp_b", dp_b0, 0);
        check("rst_res_valid", rif0.res_valid, 0);
        check("rst_res_data", rif0.res_data, 0);
        check("rst_res_index", rif0.res_index, 0);
        check("rst_err", err0, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {busy0, busy4}, 2'b00);

        // basic job: vector of 1.0, M = 4
        res_ready = 1'b1;
        launch(4, 1'b1, V1);
        check("basic_first_rd_en", row_rd_en0, 1);
        check("basic_first_addr", row_rd_addr0, 0);
        check("basic_busy", busy0, 1);
        check("basic_dp_b", dp_b0, V1);
        tick();
        check("basic_dp_in_valid", dp_in_valid0, 1);
        check("basic_second_addr", row_rd_addr0, 1);
        wait_idle("basic_timeout", 500);
        check_res("basic", 1'b0, b_q0, 4, 1);
        check("basic_done_pulses", cnt_done0 - b_dn0, 1);
        check("basic_rd_en_count", cnt_rden0 - b_rd0, 4);
        check("basic_err", err0, 0);

        // zero rows: done in the cycle after the start edge, nothing issued
        launch(0, 1'b0, '0);
        check("zero_done", done0, 1);
        check("zero_busy", busy0, 1);
        tick();
        check("zero_done_after", done0, 0);
        check("zero_busy_after", busy0, 0);
        check("zero_rd_en", cnt_rden0 - b_rd0, 0);
        check("zero_res_valid", cnt_rv0 - b_rv0, 0);

        // backpressure on the 4-entry instance
        res_ready = 1'b0;
        launch(10, 1'b1, V1);
        repeat (60) tick();
        check("bp_rd_en_stall", cnt_rden4 - b_rd4, 4);
        check("bp_busy", busy4, 1);
        check("bp_res_valid", rif4.res_valid, 1);
        check("bp_head_data", rif4.res_data, exp_x1[0]);
        check("bp_rd_en_deep", cnt_rden0 - b_rd0, 10);
        res_ready = 1'b1;
        wait_idle("bp_timeout", 1000);
        check("bp_rd_en_total", cnt_rden4 - b_rd4, 10);
        check_res("bp", 1'b1, b_q4, 10, 1);
        check("bp_done_pulses", cnt_done4 - b_dn4, 1);
        check("bp_err4", err4, 0);
        check("bp_err0", err0, 0);

        // throughput on the 32-entry instance: 100 back-to-back reads
        launch(100, 1'b0, '0);
        run = 0;
        for (int i = 0; i < 100; i++) begin
            if (row_rd_en0 && row_rd_addr0 == ROW_W'(i)) run++;
            tick();
        end
        check("tput_run", run, 100);
        check("tput_rd_en_after", row_rd_en0, 0);
        wait_idle("tput_timeout", 3000);
        check("tput_count", q_d0.size() - b_q0, 100);
        bad = 0;
        for (int k = 0; k < 100 && b_q0 + k < q_d0.size(); k++) if (q_i0[b_q0+k] != ROW_W'(k)) bad++;
        check("tput_index_order", bad, 0);
        if (q_d0.size() >= b_q0 + 100) check("tput_last_data", q_d0[b_q0+99], 32'h44C80000);
        check("tput_err", err0, 0);

        // start / vec_load during ISSUE are ignored
        launch(4, 1'b1, V2);
        tick();
        start = 1'b1;
        num_rows = ROW_W'(7);
        vec_load = 1'b1;
        vec_data = V3;
        tick();
        start = 1'b0;
        vec_load = 1'b0;
        check("ign_dp_b", dp_b0, V2);
        check("ign_busy", busy0, 1);
        wait_idle("ign_timeout", 500);
        check_res("ign", 1'b0, b_q0, 4, 2);
        check("ign_rd_en_count", cnt_rden0 - b_rd0, 4);
        check("ign_done_pulses", cnt_done0 - b_dn0, 1);
        check("ign_dp_b_after", dp_b0, V2);

        // reset mid-job after three issues
        launch(10, 1'b1, V1);
        run = 0;
        while (cnt_rden0 - b_rd0 < 3 && run < 20) begin
            tick();
            run++;
        end
        check("mid_issues", cnt_rden0 - b_rd0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_rd_en", row_rd_en0, 0);
        check("mid_rst_rd_addr", row_rd_addr0, 0);
        check("mid_rst_dp_in_valid", dp_in_valid0, 0);
        check("mid_rst_dp_b", dp_b0, 0);
        check("mid_rst_res_valid", rif0.res_valid, 0);
        check("mid_rst_res_index", rif0.res_index, 0);
        check("mid_rst_done", done0, 0);
        tick();
        rst_n = 1'b1;
        snapshot();
        repeat (40) tick();
        check("stale_seen", (cnt_dpv0 - b_dpv0) > 0, 1);
        check("stale_res_valid", cnt_rv0 - b_rv0, 0);
        check("stale_busy", busy0, 0);
        launch(2, 1'b1, V1);
        wait_idle("after_rst_timeout", 500);
        check_res("after_rst", 1'b0, b_q0, 2, 1);
        check("after_rst_done", cnt_done0 - b_dn0, 1);
        check("after_rst_err", err0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mv_row_scheduler.md
# mv_row_scheduler

Sequencer for the 16-lane floating-point dot-product pipeline (16 multipliers feeding a 4-level adder tree). It streams M matrix rows from a row buffer into the pipeline against a held operand vector and collects the M scalar results in order. Results are buffered in an output FIFO with a valid/ready handshake. Credit-based issue ensures the non-stallable pipeline never produces a result the FIFO cannot accept.

## Interface
- NUM, 16, lanes per row beat (matches datapath width)
- DW, 32, element width (IEEE-754 single)
- ROW_W, 10, row count/address width
- FIFO_DEPTH, 32, result FIFO entries; power of two, >= 2
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin job; sampled only in IDLE
- num_rows  in  ROW_W  row count M; captured with start
- vec_load  in  1  capture vec_data into operand register; honoured only in IDLE
- vec_data  in  DW*NUM  operand vector
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at job end
- row_rd_en  out  1  row buffer read strobe
- row_rd_addr  out  ROW_W  row index being read
- row_rd_data  in  DW*NUM  row data, valid 1 cycle after row_rd_en
- dp_in_valid  out  1  datapath input valid
- dp_a  out  DW*NUM  matrix row to datapath (= row_rd_data, pass-through)
- dp_b  out  DW*NUM  operand vector register
- dp_res_valid  in  1  datapath result valid
- dp_res_data  in  DW  datapath result
- res_valid  out  1  FIFO non-empty
- res_data  out  DW  head result
- res_index  out  ROW_W  row index of head result
- res_ready  in  1  consumer accepts head when res_valid & res_ready
- err_overflow  out  1  sticky; result dropped

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start & num_rows != 0 -> ISSUE, clear counters (issued, received, popped). start & num_rows == 0 -> DONE. vec_load -> dp_b <= vec_data. vec_load and start in the same cycle: load first, so the job uses the new vector.
- ISSUE: row_rd_en = (issued < M) & (credits > 0); row_rd_addr = issued. issued++ on each read. When issued == M -> DRAIN.
- credits = FIFO_DEPTH - fifo_count - inflight. inflight++ on row_rd_en, -- on dp_res_valid; both in one cycle -> unchanged.
- dp_in_valid = row_rd_en registered by one cycle.
- dp_res_valid: push {dp_res_data} into FIFO, received++. Results return in issue order. res_index = popped counter.
- Push while full: data dropped, err_overflow set; cleared only by reset. dp_res_valid in IDLE: ignored.
- DRAIN: received == M and FIFO empty (after last pop) -> DONE.
- DONE: done = 1 for one cycle -> IDLE.
- start, vec_load outside IDLE: ignored; num_rows is latched and not re-read.
- Counters are ROW_W+1 bits wide, so M = 2^ROW_W-1 is legal with no wrap ambiguity.

## Timing
- Reset values are all 0: outputs, dp_b, counters, FIFO pointers, err_overflow. State is IDLE.
- start at edge N -> first row_rd_en in cycle N+1 -> dp_in_valid in cycle N+2.
- Full throughput is one row per cycle when FIFO_DEPTH >= datapath latency + 2 and res_ready = 1.
- FIFO is show-ahead: push at edge K -> res_valid high in cycle K+1. Pop is combinational on res_valid & res_ready. Simultaneous push and pop at full is legal, but cannot occur under credit control.
- num_rows == 0: start at edge N -> done in cycle N+1, no row_rd_en.
- done is asserted in the cycle after the final pop; busy falls together with done deassertion.
- rst_n low mid-job: immediate return to IDLE with all outputs 0. In-flight datapath results arriving afterwards are ignored.

## Test plan
- Basic job: vec_load of all lanes 1.0, M = 4, row r all lanes (r+1).0, datapath model with latency 20, res_ready = 1 -> results 16.0, 32.0, 48.0, 64.0 with res_index 0..3, one done pulse, err_overflow = 0.
- Zero rows: start with num_rows = 0 -> done in cycle N+1, busy high for exactly one cycle, no row_rd_en or res_valid.
- Backpressure: FIFO_DEPTH = 4, M = 10, res_ready = 0 -> exactly 4 row_rd_en then stall. Release res_ready -> remaining 6 issued, all 10 results in order, err_overflow = 0.
- Throughput: FIFO_DEPTH = 32, latency 20, M = 100, res_ready = 1 -> row_rd_en high for 100 consecutive cycles, row_rd_addr 0..99.
- Ignored controls: start and vec_load pulsed during ISSUE -> no restart, dp_b unchanged, results match the original vector.
- Reset mid-job: rst_n low after 3 issues -> all outputs 0 asynchronously. Stale dp_res_valid pulses produce no res_valid. A new M = 2 job then completes correctly.
